// File: rtl/group_reader_pkg.sv
// -----------------------------------------------------------------------------
// group_reader_pkg
// Constants and types shared by the group RAM reader and the packer that fills
// the same RAM: address width, word width, reader FSM encoding and the parity
// helper used when GROUP_READER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package group_reader_pkg;

    localparam int ADDR_W = 10;  // group RAM address width
    localparam int WORD_W = 12;  // orbit word width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } readerState_e;

    // Even parity bit: makes the total number of ones (word + bit) even.
    function automatic logic evenParity(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/group_reader_lat.sv
// -----------------------------------------------------------------------------
// group_reader_lat
// Group RAM read-latency counter. A pulse on iStart clears and arms the
// counter; it then counts one step per clock and raises oExpire on its
// RD_LAT-th counting clock, after which it disarms itself.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   iStart  in   clear and arm the counter
//   oExpire out  high on the last counting clock
// -----------------------------------------------------------------------------
module group_reader_lat #(
    parameter int RD_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic iStart,
    output logic oExpire
);

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    logic [2:0] latCnt;
    logic       running;

    // Latency counter and armed flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            latCnt  <= 3'd0;
            running <= 1'b0;
        end else if (iStart) begin
            latCnt  <= 3'd0;
            running <= 1'b1;
        end else if (running) begin
            if (latCnt == LAST_CNT) begin
                latCnt  <= 3'd0;
                running <= 1'b0;
            end else begin
                latCnt  <= latCnt + 3'd1;
            end
        end
    end

    assign oExpire = running && (latCnt == LAST_CNT);

endmodule

// File: rtl/group_reader.sv
// -----------------------------------------------------------------------------
// group_reader
// Reads WORDS orbit words from the group RAM, one at a time, and hands each to
// the LCB serializer with a valid/ready handshake. oBusy tells the packer the
// RAM is owned by the reader for the whole frame.
//
// Optional feature: define GROUP_READER_PARITY_EN to add oParity, the even
// parity of oData, registered together with oData.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   iStart     in   frame request pulse (honoured only in IDLE)
//   iData      in   word returned by the group RAM, RD_LAT clocks after oRdEn
//   iReady     in   serializer accepts oData when oValid && iReady
//   oRdAddr    out  group RAM read address
//   oRdEn      out  group RAM read enable (one clock per word)
//   oData      out  word presented to the serializer
//   oValid     out  oData valid
//   oBusy      out  reader owns the group RAM
//   oParity    out  even parity of oData (GROUP_READER_PARITY_EN only)
//   oFrameDone out  one-clock pulse after the last word is accepted
// -----------------------------------------------------------------------------
module group_reader
    import group_reader_pkg::*;
#(
    parameter int WORDS  = 1024,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iStart,
    input  logic [WORD_W-1:0] iData,
    input  logic              iReady,
    output logic [ADDR_W-1:0] oRdAddr,
    output logic              oRdEn,
    output logic [WORD_W-1:0] oData,
    output logic              oValid,
    output logic              oBusy,
`ifdef GROUP_READER_PARITY_EN
    output logic              oParity,
`endif
    output logic              oFrameDone
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    readerState_e state;
    readerState_e nextState;
    logic         latExpire;

    // The counter is armed during READ so WAIT starts from a cleared count
    // and lasts RD_LAT clocks.
    group_reader_lat #(
        .RD_LAT (RD_LAT)
    ) uLat (
        .clk     (clk),
        .reset   (reset),
        .iStart  (state == READ),
        .oExpire (latExpire)
    );

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (iStart) begin
                    nextState = READ;
                end else begin
                    nextState = IDLE;
                end
            end
            READ: begin
                nextState = WAIT;
            end
            WAIT: begin
                if (latExpire) begin
                    nextState = HOLD;
                end else begin
                    nextState = WAIT;
                end
            end
            HOLD: begin
                if (iReady) begin
                    nextState = NEXT;
                end else begin
                    nextState = HOLD;
                end
            end
            NEXT: begin
                if (oRdAddr == LAST_ADDR) begin
                    nextState = DONE;
                end else begin
                    nextState = READ;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Registered outputs; strobes are decoded from the state being entered so
    // they line up with that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            oRdAddr    <= {ADDR_W{1'b0}};
            oRdEn      <= 1'b0;
            oData      <= {WORD_W{1'b0}};
            oValid     <= 1'b0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
`ifdef GROUP_READER_PARITY_EN
            oParity    <= 1'b0;
`endif
        end else begin
            oRdEn      <= (nextState == READ);
            oBusy      <= (nextState == READ) || (nextState == WAIT) ||
                          (nextState == HOLD) || (nextState == NEXT);
            oFrameDone <= (nextState == DONE);

            // Address only moves on frame start, word advance and frame end.
            if ((state == IDLE) && (nextState == READ)) begin
                oRdAddr <= {ADDR_W{1'b0}};
            end else if ((state == NEXT) && (nextState == READ)) begin
                oRdAddr <= oRdAddr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else if (nextState == DONE) begin
                oRdAddr <= {ADDR_W{1'b0}};
            end

            // oData (and parity) change only on the latch edge, so they are
            // stable for the whole HOLD regardless of stall length.
            if ((state == WAIT) && latExpire) begin
                oData   <= iData;
                oValid  <= 1'b1;
`ifdef GROUP_READER_PARITY_EN
                oParity <= evenParity(iData);
`endif
            end else if ((state == HOLD) && iReady) begin
                oValid  <= 1'b0;
            end
        end
    end

endmodule
